// File: rtl/c_arbiter.sv
// Round-robin steering of one broadcast clause to one of OUTPUT_CNT clause queues.
// Define C_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index priority.
module c_arbiter #(
   parameter int OUTPUT_CNT      = 4,
   parameter int CLAUSE_WIDTH    = 4,
   parameter int ELEMENT_CNT     = 1024,
   parameter int ELEMENT_BIT_CNT = $clog2(ELEMENT_CNT) + 1,
   localparam int CLAUSE_BITS    = CLAUSE_WIDTH * ELEMENT_BIT_CNT
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [CLAUSE_BITS-1:0] clause_in,
   input  logic [OUTPUT_CNT-1:0]  full_in,
   output logic [OUTPUT_CNT-1:0]  grant_out,
   output logic [CLAUSE_BITS-1:0] clause_out
);

   localparam int          PTR_W = (OUTPUT_CNT > 1) ? $clog2(OUTPUT_CNT) : 1;
   localparam int unsigned N     = OUTPUT_CNT;

   logic [OUTPUT_CNT-1:0] req;
   logic [PTR_W-1:0]      ptr;
   logic [PTR_W-1:0]      win;
   logic [PTR_W-1:0]      idx;
   logic                  found;

   // Rotating search: first requester at or after ptr, wrapping to 0.
   always_comb begin
      req   = ~full_in;
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int unsigned i = 0; i < N; i++) begin
         idx = PTR_W'((32'(ptr) + i) % N);
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

`ifdef C_ARB_FIXED_PRIO_EN
   assign ptr = '0;
`else
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ptr <= '0;
      end else if (found) begin
         ptr <= (win == PTR_W'(N - 1)) ? '0 : win + 1'b1;
      end
   end
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         grant_out  <= '0;
         clause_out <= '0;
      end else if (found) begin
         grant_out  <= OUTPUT_CNT'(1) << win;
         clause_out <= clause_in;
      end else begin
         grant_out  <= '0;
         clause_out <= '0;
      end
   end

endmodule

// File: tb/tb_c_arbiter.sv
// Self-checking bench for c_arbiter: directed vector table, hand sequences and
// randomized traffic against a distance-based reference model.
module tb_c_arbiter;

   localparam int N  = 4;
   localparam int CB = 44;

   logic          clock;
   logic          reset;
   logic [CB-1:0] clause_in;
   logic [N-1:0]  full_in;
   logic [N-1:0]  grant_out;
   logic [CB-1:0] clause_out;

   int compared   = 0;
   int mismatched = 0;

   // reference model state
   int            m_ptr = 0;
   logic [N-1:0]  exp_g;
   logic [CB-1:0] exp_c;

   c_arbiter #(.OUTPUT_CNT(4), .CLAUSE_WIDTH(4), .ELEMENT_CNT(1024)) dut (
      .clock      (clock),
      .reset      (reset),
      .clause_in  (clause_in),
      .full_in    (full_in),
      .grant_out  (grant_out),
      .clause_out (clause_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   typedef struct {
      bit            rst;
      logic [N-1:0]  full;
      logic [CB-1:0] clause;
      logic [N-1:0]  grant;
      logic [CB-1:0] cl_exp;
      string         name;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Winner = requester with the smallest forward distance from the pointer.
   task automatic model_step(input logic [N-1:0] full, input logic [CB-1:0] clause);
      int best  = -1;
      int bestd = N;
      for (int i = 0; i < N; i++) begin
         if (!full[i] && ((i - m_ptr + N) % N) < bestd) begin
            bestd = (i - m_ptr + N) % N;
            best  = i;
         end
      end
      if (best < 0) begin
         exp_g = '0;
         exp_c = '0;
      end else begin
         exp_g = '0;
         exp_g[best] = 1'b1;
         exp_c = clause;
`ifndef C_ARB_FIXED_PRIO_EN
         m_ptr = (best + 1) % N;
`endif
      end
   endtask

   task automatic cycle(input logic [N-1:0] full, input logic [CB-1:0] clause);
      full_in   = full;
      clause_in = clause;
      @(posedge clock);
      #1;
      model_step(full, clause);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      m_ptr = 0;
      check("reset_grant", 64'(grant_out), 64'(0));
      check("reset_clause", 64'(clause_out), 64'(0));
      @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic add(input bit rst, input logic [N-1:0] full, input logic [CB-1:0] clause,
                      input logic [N-1:0] grant, input logic [CB-1:0] cl_exp, input string name);
      vec_t v;
      v.rst = rst; v.full = full; v.clause = clause;
      v.grant = grant; v.cl_exp = cl_exp; v.name = name;
      vecs.push_back(v);
   endtask

   localparam logic [CB-1:0] ONES = 44'hFFF_FFFF_FFFF;
   localparam logic [CB-1:0] CA   = 44'hABC_1234_5678;

   initial begin
      logic [N-1:0]  f;
      logic [CB-1:0] c;
      reset     = 1'b0;
      full_in   = '1;
      clause_in = '0;
      #12;

      // all queues full after reset: nothing granted, clause_out stays zero
      add(1, 4'b1111, CA, 4'b0000, '0, "t1_allfull");
      for (int i = 0; i < 5; i++) add(0, 4'b1111, CA, 4'b0000, '0, "t1_allfull");
`ifndef C_ARB_FIXED_PRIO_EN
      add(0, 4'b0000, CA, 4'b0001, CA, "t3_rr");
      add(0, 4'b0000, CA, 4'b0010, CA, "t3_rr");
      add(0, 4'b0000, CA, 4'b0100, CA, "t3_rr");
      add(0, 4'b0000, CA, 4'b1000, CA, "t3_rr");
      add(0, 4'b0000, CA, 4'b0001, CA, "t3_wrap");
      add(0, 4'b0000, CA, 4'b0010, CA, "t4_ptr2");
      for (int i = 0; i < 3; i++) add(0, 4'b1011, ONES, 4'b0100, ONES, "t4_single");
      add(0, 4'b1111, ONES, 4'b0000, '0, "t4_none");
      add(1, 4'b1001, ONES, 4'b0010, ONES, "t2_pair");
      add(0, 4'b1001, ONES, 4'b0100, ONES, "t2_pair");
      add(0, 4'b1001, ONES, 4'b0010, ONES, "t2_pair");
      add(0, 4'b1001, ONES, 4'b0100, ONES, "t2_pair");
`else
      for (int i = 0; i < 3; i++) add(0, 4'b0000, CA, 4'b0001, CA, "t6_fixed");
      for (int i = 0; i < 3; i++) add(0, 4'b0011, CA, 4'b0100, CA, "t6_fixed");
      add(0, 4'b1111, CA, 4'b0000, '0, "t6_none");
`endif

      foreach (vecs[k]) begin
         if (vecs[k].rst) do_reset();
         cycle(vecs[k].full, vecs[k].clause);
         check({vecs[k].name, "_grant"}, 64'(grant_out), 64'(vecs[k].grant));
         check({vecs[k].name, "_clause"}, 64'(clause_out), 64'(vecs[k].cl_exp));
      end

      // reset asserted mid-rotation clears outputs without waiting for an edge
      do_reset();
      cycle(4'b0000, CA);
      cycle(4'b0000, CA);
      cycle(4'b0000, CA);
      check("t5_pre_grant", 64'(grant_out), 64'(exp_g));
      reset = 1'b0;
      #1;
      m_ptr = 0;
      check("t5_async_grant", 64'(grant_out), 64'(0));
      check("t5_async_clause", 64'(clause_out), 64'(0));
      @(negedge clock);
      reset = 1'b1;
      cycle(4'b0000, ONES);
      check("t5_restart_grant", 64'(grant_out), 64'(4'b0001));
      check("t5_restart_clause", 64'(clause_out), 64'(ONES));

`ifndef C_ARB_FIXED_PRIO_EN
      // fairness: each persistent requester granted once per window of k cycles
      for (int t = 0; t < 6; t++) begin
         int cnt[N];
         int k;
         f = 4'($urandom_range(0, 14));
         k = 0;
         for (int i = 0; i < N; i++) if (!f[i]) k++;
         for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < N; i++) cnt[i] = 0;
            for (int s = 0; s < k; s++) begin
               cycle(f, 44'($urandom));
               for (int i = 0; i < N; i++) if (grant_out[i]) cnt[i]++;
            end
            for (int i = 0; i < N; i++) check("fair_count", 64'(cnt[i]), 64'(f[i] ? 0 : 1));
         end
      end
`endif

      // randomized traffic against the reference model
      for (int n = 0; n < 400; n++) begin
         f = ($urandom_range(0, 7) == 0) ? 4'b1111 : 4'($urandom);
         c = 44'({$urandom, $urandom});
         cycle(f, c);
         check("rand_grant", 64'(grant_out), 64'(exp_g));
         check("rand_clause", 64'(clause_out), 64'(exp_c));
         check("rand_onehot0", 64'($onehot0(grant_out)), 64'(1));
         check("rand_full_not_granted", 64'(grant_out & f), 64'(0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
